// File: rtl/rr_encoder_4to2.sv
// Round-robin 4-to-2 encoder: picks one of four requesters with rotating priority and presents index + one-hot grant.
// Latency: one cycle from sampled i_req to registered o_valid/o_sel/o_grant/o_multi.
// Backpressure: selection is held frozen while o_valid && !i_ready; a new capture only when idle or being accepted.
module rr_encoder_4to2 #(
    parameter logic [1:0] PTR_INIT = 2'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_en,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_sel,
    output logic [3:0] o_grant,
    output logic       o_multi
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;

    logic       accept;
    logic       cap;
    logic [1:0] eff_ptr;
    logic [1:0] winner;
    logic [1:0] idx;
    logic [2:0] req_cnt;
    logic       multi;

    // o_valid is a decode of the state register only, so no input reaches it combinationally
    assign o_valid = (state == HOLD);

    // Capture/accept qualification, rotating-priority scan and request population count
    always_comb begin
        accept  = o_valid && i_ready;
        cap     = i_en && (|i_req) && (!o_valid || i_ready);
        // On accept the just-served index drops to lowest priority immediately
        eff_ptr = accept ? (o_sel + 2'd1) : ptr;
        winner  = eff_ptr;
        idx     = eff_ptr;
        // Scan from farthest to nearest offset so the nearest set bit overwrites last and wins
        for (int i = 3; i >= 0; i--) begin
            idx = eff_ptr + i[1:0];
            if (i_req[idx]) begin
                winner = idx;
            end
        end
        req_cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            req_cnt = req_cnt + {2'b00, i_req[k]};
        end
        multi = (req_cnt >= 3'd2);
    end

    // FSM with registered selection outputs and priority pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_sel   <= 2'b00;
            o_grant <= 4'b0000;
            o_multi <= 1'b0;
            ptr     <= PTR_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (cap) begin
                        state   <= HOLD;
                        o_sel   <= winner;
                        o_grant <= 4'b0001 << winner;
                        o_multi <= multi;
                    end
                end
                HOLD: begin
                    if (cap) begin
                        // back-to-back: accept the current entry and load the next winner
                        o_sel   <= winner;
                        o_grant <= 4'b0001 << winner;
                        o_multi <= multi;
                    end else if (i_ready) begin
                        // o_sel and o_multi keep their last values after the hand-off
                        state   <= IDLE;
                        o_grant <= 4'b0000;
                    end
                end
                default: state <= IDLE;
            endcase
            // Pointer moves only on accept, never on capture alone
            if (accept) begin
                ptr <= o_sel + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_encoder_4to2.sv
// Scoreboard bench for rr_encoder_4to2: directed vectors push expected selections, a monitor checks them.
// Inputs are driven 1 time unit after the rising edge; the monitor samples on the falling edge.
// Each held selection is compared every cycle it is presented and popped when i_ready accepts it.
module tb_rr_encoder_4to2;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       en;
    logic       rdy;
    logic       valid;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       multi;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushes   = 0;
    int   pops     = 0;

    rr_encoder_4to2 #(.PTR_INIT(2'd0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_en    (en),
        .i_ready (rdy),
        .o_valid (valid),
        .o_sel   (sel),
        .o_grant (grant),
        .o_multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the bench always reaches its summary
    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] g, input logic m);
        exp_t e;
        e.sel   = s;
        e.grant = g;
        e.multi = m;
        q.push_back(e);
        pushes++;
    endtask

    task automatic drive(input logic [3:0] r, input logic e, input logic rd);
        req = r;
        en  = e;
        rdy = rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare presented selection against scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected: actual sel=%0d grant=%b with empty scoreboard at %0t", sel, grant, $time);
                end else begin
                    chk("mon_sel",   {6'd0, sel},   {6'd0, q[0].sel});
                    chk("mon_grant", {4'd0, grant}, {4'd0, q[0].grant});
                    chk("mon_multi", {7'd0, multi}, {7'd0, q[0].multi});
                    if (rdy) begin
                        void'(q.pop_front());
                        pops++;
                    end
                end
            end else begin
                chk("mon_idle_grant", {4'd0, grant}, 8'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        #12;
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_sel",   {6'd0, sel},   8'd0);
        chk("rst_grant", {4'd0, grant}, 8'd0);
        chk("rst_multi", {7'd0, multi}, 8'd0);
        rst_n = 1'b1;
        cyc();

        // Single request, then release: ptr -> 3
        drive(4'b0100, 1'b1, 1'b1); push(2'd2, 4'b0100, 1'b0); cyc();
        chk("single_valid", {7'd0, valid}, 8'd1);
        drive(4'b0000, 1'b1, 1'b1); cyc();
        chk("single_done", {7'd0, valid}, 8'd0);

        // Fairness with all requesting, starting from ptr=3: 3,0,1,2,3
        drive(4'b1111, 1'b1, 1'b1);
        push(2'd3, 4'b1000, 1'b1); cyc();
        push(2'd0, 4'b0001, 1'b1); cyc();
        chk("rr_valid_mid", {7'd0, valid}, 8'd1);
        push(2'd1, 4'b0010, 1'b1); cyc();
        push(2'd2, 4'b0100, 1'b1); cyc();
        push(2'd3, 4'b1000, 1'b1); cyc();
        drive(4'b0000, 1'b1, 1'b1); cyc();
        chk("rr_done", {7'd0, valid}, 8'd0);

        // Backpressure: ptr=0, capture 0 and hold while requests vanish
        drive(4'b0011, 1'b1, 1'b1); push(2'd0, 4'b0001, 1'b1); cyc();
        drive(4'b0011, 1'b1, 1'b0); cyc(); cyc(); cyc();
        drive(4'b0000, 1'b1, 1'b0); cyc();
        chk("bp_held_valid", {7'd0, valid}, 8'd1);
        chk("bp_held_sel",   {6'd0, sel},   8'd0);
        drive(4'b0000, 1'b1, 1'b1); cyc();
        chk("bp_done", {7'd0, valid}, 8'd0);

        // ptr=1: capture 1, then 3, then wrap 3->0 with req=1001
        drive(4'b0011, 1'b1, 1'b0); push(2'd1, 4'b0010, 1'b1); cyc();
        drive(4'b1000, 1'b1, 1'b1); push(2'd3, 4'b1000, 1'b0); cyc();
        drive(4'b1001, 1'b1, 1'b1); push(2'd0, 4'b0001, 1'b1); cyc();
        chk("wrap_sel", {6'd0, sel}, 8'd0);
        drive(4'b0000, 1'b1, 1'b1); cyc();
        chk("wrap_done", {7'd0, valid}, 8'd0);

        // Enable gating (ptr=1)
        drive(4'b1000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("en_gate_valid", {7'd0, valid}, 8'd0);
        end
        drive(4'b1000, 1'b1, 1'b1); push(2'd3, 4'b1000, 1'b0); cyc();
        chk("en_cap_valid", {7'd0, valid}, 8'd1);
        drive(4'b0100, 1'b1, 1'b1); push(2'd2, 4'b0100, 1'b0); cyc();
        drive(4'b0000, 1'b1, 1'b0); cyc();
        chk("pre_rst_sel", {6'd0, sel}, 8'd2);

        // Async reset mid-HOLD, between edges
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, valid}, 8'd0);
        chk("arst_grant", {4'd0, grant}, 8'd0);
        q.delete();
        pops++;
        #1;
        rst_n = 1'b1;
        cyc();
        drive(4'b1111, 1'b1, 1'b1); push(2'd0, 4'b0001, 1'b1); cyc();
        drive(4'b0000, 1'b1, 1'b1); cyc();
        chk("final_idle", {7'd0, valid}, 8'd0);
        cyc();

        chk("sb_empty", 8'(q.size()), 8'd0);
        chk("sb_balance", 8'(pops), 8'(pushes));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
